// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_param
// Brief    : Parametrised SPI master with one-hot selects, clock divider,
//            LSB/MSB ordering and back-to-back burst words.
// Revision : 1.0
// ============================================================================
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int EC_W = $clog2(2 * DATA_W + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LEAD  = 3'd1;
    localparam logic [2:0] c_XFER  = 3'd2;
    localparam logic [2:0] c_TRAIL = 3'd3;
    localparam logic [2:0] c_END   = 3'd4;

    localparam logic [EC_W-1:0] c_LAST_EDGE = EC_W'(2 * DATA_W - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [DIV_W-1:0]  r_tick;
    logic [DIV_W-1:0]  r_div;
    logic [EC_W-1:0]   r_edge_cnt;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_lsb;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_busy;
    logic              r_sclk;
    logic              r_mosi;
    logic [NUM_SS-1:0] r_ss_n;

    logic              w_tick_end;
    logic              w_last_edge;
    logic              w_odd_edge;
    logic [NUM_SS-1:0] w_sel_n;
    logic              w_load_lsb;
    logic              w_first_bit;
    logic [DATA_W-1:0] w_tx_after_first;
    logic              w_tx_head;
    logic [DATA_W-1:0] w_tx_shifted;
    logic [DATA_W-1:0] w_rx_next;

    assign w_tick_end  = (r_tick == r_div);
    assign w_last_edge = (r_edge_cnt == c_LAST_EDGE);
    // r_edge_cnt counts completed edges, so the upcoming edge is odd when it is even
    assign w_odd_edge  = ~r_edge_cnt[0];

    // Out-of-range indices match no bit, so no select is asserted
    for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_ss_dec
        assign w_sel_n[gi] = (ss_sel != SS_W'(gi));
    end

    // A word is loaded from IDLE with live config, or from END with the latched config
    assign w_load_lsb       = (r_state == c_IDLE) ? lsb_first : r_lsb;
    assign w_first_bit      = w_load_lsb ? tx_data[0] : tx_data[DATA_W-1];
    assign w_tx_after_first = w_load_lsb ? (tx_data >> 1) : (tx_data << 1);

    assign w_tx_head    = r_lsb ? r_tx_shift[0] : r_tx_shift[DATA_W-1];
    assign w_tx_shifted = r_lsb ? (r_tx_shift >> 1) : (r_tx_shift << 1);
    assign w_rx_next    = r_lsb ? {miso, r_rx_shift[DATA_W-1:1]}
                                : {r_rx_shift[DATA_W-2:0], miso};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_LEAD;
            c_LEAD:  if (w_tick_end) w_state_next = c_XFER;
            c_XFER:  if (w_tick_end && w_last_edge) w_state_next = c_TRAIL;
            c_TRAIL: if (w_tick_end) w_state_next = c_END;
            c_END:   w_state_next = start ? c_XFER : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (r_state == c_IDLE) || (r_state == c_END);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tick     <= '0;
            r_div      <= '0;
            r_edge_cnt <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss_n     <= '1;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_sclk     <= cpol;
                    r_tick     <= '0;
                    r_edge_cnt <= '0;
                    if (start) begin
                        r_div  <= clk_div;
                        r_cpol <= cpol;
                        r_cpha <= cpha;
                        r_lsb  <= lsb_first;
                        r_ss_n <= w_sel_n;
                        r_busy <= 1'b1;
                        if (!cpha) begin
                            r_mosi     <= w_first_bit;
                            r_tx_shift <= w_tx_after_first;
                        end else begin
                            r_tx_shift <= tx_data;
                        end
                    end
                end
                c_LEAD: begin
                    r_sclk <= r_cpol;
                    if (w_tick_end) begin
                        r_tick     <= '0;
                        r_edge_cnt <= '0;
                    end else begin
                        r_tick <= r_tick + DIV_W'(1);
                    end
                end
                c_XFER: begin
                    if (w_tick_end) begin
                        r_tick     <= '0;
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + EC_W'(1);
                        if (w_odd_edge) begin
                            if (!r_cpha) begin
                                r_rx_shift <= w_rx_next;
                            end else begin
                                r_mosi     <= w_tx_head;
                                r_tx_shift <= w_tx_shifted;
                            end
                        end else begin
                            if (r_cpha) begin
                                r_rx_shift <= w_rx_next;
                            end else if (!w_last_edge) begin
                                r_mosi     <= w_tx_head;
                                r_tx_shift <= w_tx_shifted;
                            end
                        end
                    end else begin
                        r_tick <= r_tick + DIV_W'(1);
                    end
                end
                c_TRAIL: begin
                    r_sclk <= r_cpol;
                    if (w_tick_end) begin
                        r_tick     <= '0;
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_tick <= r_tick + DIV_W'(1);
                    end
                end
                c_END: begin
                    r_sclk     <= r_cpol;
                    r_tick     <= '0;
                    r_edge_cnt <= '0;
                    if (start) begin
                        // Burst: selects and config stay as latched for the first word
                        if (!r_cpha) begin
                            r_mosi     <= w_first_bit;
                            r_tx_shift <= w_tx_after_first;
                        end else begin
                            r_tx_shift <= tx_data;
                        end
                    end else begin
                        r_ss_n <= '1;
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_tick <= '0;
                end
            endcase
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;
    assign sclk     = r_sclk;
    assign mosi     = r_mosi;
    assign ss_n     = r_ss_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_param
// Brief    : Directed, table-driven bench for spi_master_param.
// Revision : 1.0
// ============================================================================
module tb_spi_master_param;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance 0: DATA_W=8, NUM_SS=4
    logic       start0, cpol0, cpha0, lsb0, ready0, rxv0, busy0, sclk0, mosi0, miso0;
    logic [7:0] tx0, div0, rxd0;
    logic [1:0] sel0;
    logic [3:0] ssn0;

    // Instance 1: DATA_W=16, NUM_SS=3
    logic        s1_start, s1_ready, s1_rxv, s1_busy, s1_sclk, s1_mosi;
    logic        s1_cpol, s1_cpha, s1_lsb;
    logic [15:0] s1_tx, s1_rxd;
    logic [7:0]  s1_div;
    logic [1:0]  s1_sel;
    logic [2:0]  s1_ssn;

    spi_master_param #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .tx_data(tx0), .ss_sel(sel0),
        .cpol(cpol0), .cpha(cpha0), .lsb_first(lsb0), .clk_div(div0),
        .tx_ready(ready0), .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0),
        .sclk(sclk0), .mosi(mosi0), .miso(miso0), .ss_n(ssn0)
    );

    spi_master_param #(.DATA_W(16), .NUM_SS(3), .DIV_W(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(s1_start), .tx_data(s1_tx), .ss_sel(s1_sel),
        .cpol(s1_cpol), .cpha(s1_cpha), .lsb_first(s1_lsb), .clk_div(s1_div),
        .tx_ready(s1_ready), .rx_data(s1_rxd), .rx_valid(s1_rxv), .busy(s1_busy),
        .sclk(s1_sclk), .mosi(s1_mosi), .miso(s1_mosi), .ss_n(s1_ssn)
    );

    // Mode-0 slave: presents its word bit by bit, advancing after each rising sclk,
    // and logs mosi as seen on each rising sclk.
    logic       slv_clr, slv_loop, slv_lsb;
    logic [7:0] slv_word, mon_bits;
    logic [3:0] slv_idx;

    always @(posedge sclk0 or posedge slv_clr) begin
        if (slv_clr) begin
            slv_idx  = 4'd0;
            mon_bits = 8'd0;
        end else begin
            slv_idx  = slv_idx + 4'd1;
            mon_bits = {mon_bits[6:0], mosi0};
        end
    end

    assign miso0 = slv_loop ? mosi0
                 : (slv_lsb ? slv_word[slv_idx[2:0]] : slv_word[3'd7 - slv_idx[2:0]]);

    typedef struct packed {
        logic [7:0]  tx;
        logic        cpol;
        logic        cpha;
        logic        lsb;
        logic [7:0]  div;
        logic [1:0]  sel;
        logic        loopb;
        logic [7:0]  slv;
        logic [7:0]  exp_rx;
        logic [15:0] exp_ss;
    } vec_t;

    vec_t vecs [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic run0(input vec_t v);
        int         ss_low, ss_bad, nval;
        logic [7:0] rx;
        logic [3:0] exp_ssn;
        logic       done;
        ss_low = 0; ss_bad = 0; nval = 0; rx = 8'h00; done = 1'b0;
        exp_ssn = ~(4'b0001 << v.sel);
        @(negedge clk);
        tx0 = v.tx; cpol0 = v.cpol; cpha0 = v.cpha; lsb0 = v.lsb; div0 = v.div; sel0 = v.sel;
        slv_loop = v.loopb; slv_lsb = v.lsb; slv_word = v.slv;
        @(negedge clk);
        @(negedge clk);
        check("idle_sclk_before", sclk0, v.cpol);
        check("ready_idle", ready0, 1);
        slv_clr = 1'b1;
        #1 slv_clr = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (ssn0 == exp_ssn) ss_low++;
            else if (ssn0 != 4'hF) ss_bad++;
            if (rxv0) begin
                nval++;
                rx = rxd0;
            end
            if (!busy0) begin
                done = 1'b1;
                break;
            end
            // Inputs wiggled mid-transfer must have no effect
            if (n == 10) begin
                start0 = 1'b1; tx0 = ~v.tx; sel0 = ~v.sel; cpol0 = ~v.cpol;
            end
            if (n == 11) begin
                start0 = 1'b0; tx0 = v.tx; sel0 = v.sel; cpol0 = v.cpol;
            end
            @(negedge clk);
        end
        check("xfer_done", done, 1);
        check("rx_data", rx, v.exp_rx);
        check("ss_low_cycles", ss_low, v.exp_ss);
        check("ss_other", ss_bad, 0);
        check("rx_valid_pulses", nval, 1);
        check("idle_sclk_after", sclk0, v.cpol);
        if (!v.cpol && !v.cpha)
            check("mosi_bits", mon_bits, v.lsb ? rev8(v.tx) : v.tx);
    endtask

    task automatic run_burst();
        logic [7:0] rxs [0:2];
        int         tval [0:2];
        int         nval, act, ss_bad;
        logic       done;
        nval = 0; act = 0; ss_bad = 0; done = 1'b0;
        for (int i = 0; i < 3; i++) begin rxs[i] = 8'h00; tval[i] = 0; end
        @(negedge clk);
        cpol0 = 1'b0; cpha0 = 1'b0; lsb0 = 1'b0; div0 = 8'd1; sel0 = 2'd2; slv_loop = 1'b1;
        tx0 = 8'h11;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        tx0 = 8'h22;
        for (int n = 0; n < 400; n++) begin
            if (!busy0) begin
                done = 1'b1;
                break;
            end
            if (act == 1) tx0 = 8'h33;
            else if (act == 2) start0 = 1'b0;
            act = 0;
            if (ssn0 != 4'b1011) ss_bad++;
            if (rxv0) begin
                if (nval < 3) begin
                    rxs[nval]  = rxd0;
                    tval[nval] = n;
                end
                nval++;
                act = nval;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        check("burst_done", done, 1);
        check("burst_pulses", nval, 3);
        check("burst_rx0", rxs[0], 8'h11);
        check("burst_rx1", rxs[1], 8'h22);
        check("burst_rx2", rxs[2], 8'h33);
        check("burst_ss_low", ss_bad, 0);
        check("burst_period01", tval[1] - tval[0], 35);
        check("burst_period12", tval[2] - tval[1], 35);
    endtask

    task automatic run_reset_mid();
        int   edges, nval;
        logic prev, hit;
        edges = 0; nval = 0; hit = 1'b0;
        @(negedge clk);
        cpol0 = 1'b0; cpha0 = 1'b0; lsb0 = 1'b0; div0 = 8'd1; sel0 = 2'd0; slv_loop = 1'b1;
        tx0 = 8'hFF;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        prev = sclk0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rxv0) nval++;
            if (sclk0 != prev) edges++;
            prev = sclk0;
            if (edges == 5) begin
                hit = 1'b1;
                break;
            end
        end
        check("reset_edge5_reached", hit, 1);
        reset_n = 1'b0;
        @(negedge clk);
        if (rxv0) nval++;
        check("rst_ss_n", ssn0, 4'hF);
        check("rst_sclk", sclk0, 0);
        check("rst_busy", busy0, 0);
        check("rst_rx_data", rxd0, 0);
        check("rst_no_valid", nval, 0);
        reset_n = 1'b1;
    endtask

    task automatic run1(input logic [7:0] div, input int exp_period, input int exp_busy);
        int          busy_cnt, bad, nrise, nval;
        int          rise [0:1];
        logic [15:0] rx;
        logic        prev, done;
        busy_cnt = 0; bad = 0; nrise = 0; nval = 0; rx = 16'h0; done = 1'b0;
        rise[0] = 0; rise[1] = 0;
        @(negedge clk);
        s1_tx = 16'hBEEF; s1_sel = 2'd3; s1_div = div;
        @(negedge clk);
        s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        prev = s1_sclk;
        for (int n = 0; n < 20000; n++) begin
            if (!s1_busy) begin
                done = 1'b1;
                break;
            end
            busy_cnt++;
            if (s1_ssn != 3'b111) bad++;
            if (s1_sclk && !prev) begin
                if (nrise < 2) rise[nrise] = n;
                nrise++;
            end
            prev = s1_sclk;
            if (s1_rxv) begin
                nval++;
                rx = s1_rxd;
            end
            @(negedge clk);
        end
        check("w16_done", done, 1);
        check("w16_rx", rx, 16'hBEEF);
        check("w16_valid", nval, 1);
        check("w16_no_ss", bad, 0);
        check("w16_sclk_period", rise[1] - rise[0], exp_period);
        check("w16_busy_cycles", busy_cnt, exp_busy);
    endtask

    initial begin
        //          tx     cpol  cpha  lsb   div   sel   loop  slv    exp_rx ss
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 1'b0, 8'h3C, 8'h3C, 16'd37};
        vecs[1] = '{8'h96, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 1'b1, 8'h00, 8'h96, 16'd37};
        vecs[2] = '{8'h96, 1'b0, 1'b1, 1'b0, 8'd1, 2'd2, 1'b1, 8'h00, 8'h96, 16'd37};
        vecs[3] = '{8'h96, 1'b1, 1'b0, 1'b0, 8'd1, 2'd3, 1'b1, 8'h00, 8'h96, 16'd37};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 1'b0, 8'd1, 2'd0, 1'b1, 8'h00, 8'h96, 16'd37};
        vecs[5] = '{8'h01, 1'b0, 1'b0, 1'b1, 8'd1, 2'd2, 1'b0, 8'h80, 8'h80, 16'd37};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'd3, 2'd1, 1'b1, 8'h00, 8'h5A, 16'd73};
        vecs[7] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'd0, 2'd3, 1'b1, 8'h00, 8'hC3, 16'd19};

        reset_n = 1'b0;
        start0 = 1'b0; tx0 = 8'h00; sel0 = 2'd0; cpol0 = 1'b0; cpha0 = 1'b0; lsb0 = 1'b0; div0 = 8'd0;
        s1_start = 1'b0; s1_tx = 16'h0; s1_sel = 2'd0; s1_div = 8'd0;
        s1_cpol = 1'b0; s1_cpha = 1'b0; s1_lsb = 1'b0;
        slv_clr = 1'b0; slv_loop = 1'b1; slv_lsb = 1'b0; slv_word = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_sclk", sclk0, 0);
        check("reset_mosi", mosi0, 0);
        check("reset_ss_n", ssn0, 4'hF);
        check("reset_rx_data", rxd0, 0);
        check("reset_rx_valid", rxv0, 0);
        check("reset_busy", busy0, 0);
        check("reset_ready", ready0, 1);
        check("reset_ss_n_w16", s1_ssn, 3'b111);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) run0(vecs[i]);
        run_burst();
        run_reset_mid();
        run0(vecs[0]);
        run1(8'd0, 2, 35);
        run1(8'd255, 512, 8705);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised successor to the team's 8-bit SPI master. It adds configurable word width, multiple one-hot slave selects, a programmable clock divider and LSB/MSB-first ordering. It also adds back-to-back burst transfers that keep the slave selected between words. It sits between a register/control block and off-chip SPI peripherals.

Parameters:
DATA_W, 8, bits per SPI word (2..32)
NUM_SS, 4, number of slave-select outputs (1..16)
DIV_W, 8, width of clk_div; SCLK half-period = clk_div+1 clk cycles

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset (sampled on rising clk)
start  in  1  request a word; accepted only when tx_ready=1
tx_data  in  DATA_W  word to transmit, latched on accepted start
ss_sel  in  max(1,$clog2(NUM_SS))  slave index, latched on start from IDLE
cpol  in  1  clock polarity, latched on start from IDLE
cpha  in  1  clock phase, latched on start from IDLE
lsb_first  in  1  1=LSB first, latched on start from IDLE
clk_div  in  DIV_W  half-period minus one, latched on start from IDLE
tx_ready  out  1  high in IDLE and END; start is accepted when tx_ready=1
rx_data  out  DATA_W  last received word, held until next word completes
rx_valid  out  1  one-cycle pulse when rx_data updates
busy  out  1  high from the cycle after an accepted start until return to IDLE
sclk  out  1  registered SPI clock
mosi  out  1  registered serial data out
miso  in  1  serial data in
ss_n  out  NUM_SS  one-hot active-low selects

Behaviour:
- Reset (reset_n=0 at a clk edge, any state): state=IDLE; sclk=0; mosi=0; ss_n=all 1; rx_data=0; rx_valid=0; busy=0; shift registers, counters and latched config=0. Reset is honoured mid-transfer with no completion pulse.
- Half-period H=clk_div_latched+1. A tick counter counts 0..H-1 and reloads; clk_div=0 gives sclk=clk/2.
- States: IDLE, LEAD, XFER, TRAIL, END.
- IDLE: sclk=cpol input (registered), ss_n all 1, tx_ready=1. On start, latch tx_data and config, then go to LEAD.
- LEAD (H cycles): ss_n[ss_sel]=0. If cpha=0, mosi=first bit (MSB, or LSB if lsb_first). Then go to XFER.
- XFER: sclk toggles at the end of each H-cycle interval, for 2*DATA_W edges total.
  - cpha=0: odd edges sample miso; even edges except the last drive the next bit.
  - cpha=1: odd edges drive the next bit; even edges sample miso.
  - miso is sampled on the same clk edge that toggles sclk.
  - After edge 2*DATA_W, sclk equals cpol; go to TRAIL.
- TRAIL (H cycles): sclk idle, ss_n held, then go to END.
- END (1 cycle): rx_data<=assembled word; rx_valid=1; tx_ready=1.
  - start=1: burst. Latch new tx_data; keep ss_n, config and ss_sel (new ss_sel/config ignored). If cpha=0, load first bit on mosi. Go directly to XFER.
  - start=0: go to IDLE; ss_n deasserts and busy falls the next cycle.
- Bit order: MSB-first fills rx_data from bit DATA_W-1 down; LSB-first fills from bit 0 up, so the first bit received lands in bit 0.
- ss_sel>=NUM_SS: no ss_n asserted; the transfer still runs and rx_data captures miso.
- start while tx_ready=0 is ignored. Input changes during busy have no effect.
- Single-word timing: ss_n low for (2*DATA_W+2)*H+1 cycles. Burst word period is (2*DATA_W+1)*H+1 cycles, with ss_n continuously low.

Test Plan:
- DATA_W=8, clk_div=1, cpol=0, cpha=0, MSB, tx=0xA5, slave returns 0x3C: mosi bits 1,0,1,0,0,1,0,1 valid before each rising sclk; rx_data=0x3C; one rx_valid pulse; ss_n[ss_sel] low exactly 37 cycles.
- All four cpol/cpha modes with tx=0x96, loopback miso=mosi: rx_data=0x96; sclk idles at cpol before and after each transfer.
- lsb_first=1, tx=0x01, slave sends 0x80 LSB-first: first mosi bit=1; rx_data=0x80.
- Burst: start held through END for 3 words 0x11,0x22,0x33: ss_n stays low throughout; three rx_valid pulses; busy never drops.
- reset_n=0 at XFER edge 5: next cycle ss_n all 1, sclk=0, busy=0, rx_data=0, no rx_valid; a new transfer then completes normally.
- clk_div=0 and clk_div=255 with DATA_W=16, NUM_SS=3, ss_sel=3: sclk period 2 and 512 cycles; no ss_n asserted; rx_data captures miso.
